// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//
// Trace capture for the pipelined core. Every retiring (WB-stage)
// instruction is written into a circular trace RAM while capture is armed.
// Capture stops a programmable number of entries after a trigger, either a
// PC match or, with trig_en=0, the first captured entry. The held entries
// are then drained oldest-first over a valid/ready read port.
//
// Handshake: rd_valid && rd_ready in the same cycle transfers one entry.
// rd_entry is a combinational read that holds stable while
// rd_valid && !rd_ready. rd_valid never depends on rd_ready.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous reset, active low
//   arm       pulse: clear the buffer and start capture (wins over all else)
//   trig_en   1: trigger on wb_pc == trig_pc; 0: trigger on first capture
//   trig_pc   trigger PC, compared live
//   post_cnt  entries to keep after the trigger entry, latched on arm
//   wb_*      retiring instruction bus
//   rd_valid  trace entry available on rd_entry
//   rd_ready  consumer accepts the entry
//   rd_entry  {wb_we, wb_rd, wb_data, wb_instr, wb_pc}
//   state     0 IDLE, 1 PRETRIG, 2 POSTTRIG, 3 DONE
//   count     valid entries held, 0..DEPTH
//   trig_idx  readout position of the trigger entry (valid in DONE)
module pipeline_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic [$clog2(DEPTH)-1:0]   post_cnt,
    input  logic                       wb_valid,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [XLEN-1:0]            wb_instr,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [4:0]                 wb_rd,
    input  logic                       wb_we,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [3*XLEN+5:0]          rd_entry,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   trig_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3*XLEN + 6;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRETRIG  = 2'd1,
        POSTTRIG = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   remaining_q, remaining_d;
    logic [AW-1:0]   post_lat_q, post_lat_d;
    logic [AW-1:0]   trig_idx_q, trig_idx_d;

    logic [EW-1:0]   ram [DEPTH];

    logic            capture;
    logic            hit;
    logic            pop;
    logic [AW-1:0]   cap_wr_ptr;
    logic [AW:0]     cap_count;
    logic [AW:0]     done_trig_idx;

    // arm takes priority: a capture or pop in the arm cycle is dropped.
    assign capture = wb_valid && !arm
                     && (state_q == PRETRIG || state_q == POSTTRIG);
    assign hit     = capture && (state_q == PRETRIG)
                     && (!trig_en || wb_pc == trig_pc);
    assign rd_valid = (state_q == DONE) && (count_q != '0);
    assign pop      = rd_valid && rd_ready && !arm;

    // Pointer/count values as they will be after this cycle's capture;
    // DONE bookkeeping is derived from these so the triggering write counts.
    assign cap_wr_ptr    = wr_ptr_q + 1'b1;
    assign cap_count     = (count_q == FULL) ? count_q : count_q + 1'b1;
    assign done_trig_idx = cap_count - (AW+1)'(1) - {1'b0, post_lat_q};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        post_lat_d  = post_lat_q;
        trig_idx_d  = trig_idx_q;

        if (arm) begin
            state_d     = PRETRIG;
            wr_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
            // post_cnt is AW bits wide, so it can never exceed DEPTH-1 and the
            // trigger entry always survives until readout.
            post_lat_d  = post_cnt;
        end else begin
            case (state_q)
                PRETRIG: begin
                    if (capture) begin
                        wr_ptr_d = cap_wr_ptr;
                        count_d  = cap_count;
                        if (hit) begin
                            if (post_lat_q == '0) begin
                                state_d    = DONE;
                                rd_ptr_d   = cap_wr_ptr - cap_count[AW-1:0];
                                trig_idx_d = done_trig_idx[AW-1:0];
                            end else begin
                                state_d     = POSTTRIG;
                                remaining_d = post_lat_q;
                            end
                        end
                    end
                end
                POSTTRIG: begin
                    if (capture) begin
                        wr_ptr_d    = cap_wr_ptr;
                        count_d     = cap_count;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == AW'(1)) begin
                            state_d    = DONE;
                            rd_ptr_d   = cap_wr_ptr - cap_count[AW-1:0];
                            trig_idx_d = done_trig_idx[AW-1:0];
                        end
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            post_lat_q  <= '0;
            trig_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            post_lat_q  <= post_lat_d;
            trig_idx_q  <= trig_idx_d;
        end
    end

    // Trace RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            ram[wr_ptr_q] <= {wb_we, wb_rd, wb_data, wb_instr, wb_pc};
        end
    end

    // Drive zeros whenever nothing is offered so rd_entry reads 0 out of reset.
    assign rd_entry = rd_valid ? ram[rd_ptr_q] : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign trig_idx = trig_idx_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int EW    = 3*XLEN + 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            arm = 1'b0;
    logic            trig_en = 1'b0;
    logic [XLEN-1:0] trig_pc = '0;
    logic [AW-1:0]   post_cnt = '0;
    logic            wb_valid = 1'b0;
    logic [XLEN-1:0] wb_pc = '0;
    logic [XLEN-1:0] wb_instr = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic [4:0]      wb_rd = '0;
    logic            wb_we = 1'b0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [EW-1:0]   rd_entry;
    logic [1:0]      state;
    logic [AW:0]     count;
    logic [AW-1:0]   trig_idx;

    int tests_run = 0;
    int tests_failed = 0;
    logic [EW-1:0] exp_q[$];

    pipeline_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_cnt(post_cnt), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_instr(wb_instr), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_entry(rd_entry),
        .state(state), .count(count), .trig_idx(trig_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Bench-side construction of the entry expected for a given PC.
    function automatic logic [EW-1:0] mk_entry(input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] data;
        instr = pc ^ 32'h1000_0013;
        data  = ~pc;
        return {pc[2], pc[6:2], data, instr, pc};
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_arm(input logic ten, input logic [XLEN-1:0] tpc,
                          input logic [AW-1:0] pc_n);
        trig_en  = ten;
        trig_pc  = tpc;
        post_cnt = pc_n;
        arm      = 1'b1;
        step();
        arm      = 1'b0;
    endtask

    task automatic set_wb(input logic [XLEN-1:0] pc);
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_instr = pc ^ 32'h1000_0013;
        wb_data  = ~pc;
        wb_rd    = pc[6:2];
        wb_we    = pc[2];
    endtask

    task automatic retire(input logic [XLEN-1:0] pc);
        set_wb(pc);
        step();
        wb_valid = 1'b0;
    endtask

    task automatic retire_range(input logic [XLEN-1:0] first, input int n);
        for (int i = 0; i < n; i++) retire(first + XLEN'(4*i));
    endtask

    // Pops everything in exp_q, checking each entry, then checks rd_valid drops.
    task automatic drain(input string tag);
        logic [EW-1:0] e;
        rd_ready = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 128'(rd_valid), 128'(1));
            check({tag, "_entry"}, 128'(rd_entry), 128'(e));
            step();
        end
        rd_ready = 1'b0;
        check({tag, "_empty_valid"}, 128'(rd_valid), 128'(0));
        check({tag, "_empty_count"}, 128'(count), 128'(0));
    endtask

    logic [EW-1:0] held;

    initial begin
        // reset state
        #12;
        check("rst_state", 128'(state), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_valid", 128'(rd_valid), 128'(0));
        check("rst_entry", 128'(rd_entry), 128'(0));
        check("rst_trig_idx", 128'(trig_idx), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        step();
        retire(32'h100);
        check("idle_ignore_state", 128'(state), 128'(0));
        check("idle_ignore_count", 128'(count), 128'(0));

        // reset mid-POSTTRIG
        do_arm(1'b0, 32'h0, 3'd7);
        retire_range(32'h0, 5);
        check("mid_state", 128'(state), 128'(2));
        check("mid_count", 128'(count), 128'(5));
        rst = 1'b0;
        #2;
        check("abort_state", 128'(state), 128'(0));
        check("abort_count", 128'(count), 128'(0));
        check("abort_valid", 128'(rd_valid), 128'(0));
        step();
        rst = 1'b1;
        step();
        retire_range(32'h0, 2);
        check("post_rst_state", 128'(state), 128'(0));
        check("post_rst_count", 128'(count), 128'(0));

        // no-wrap, trigger on first capture
        do_arm(1'b0, 32'h0, 3'd3);
        retire_range(32'h0, 4);
        check("nowrap_state", 128'(state), 128'(3));
        check("nowrap_count", 128'(count), 128'(4));
        check("nowrap_trig_idx", 128'(trig_idx), 128'(0));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_entry(32'(4*i)));
        drain("nowrap");

        // wrap with PC trigger, then backpressure
        do_arm(1'b1, 32'h40, 3'd2);
        retire_range(32'h0, 19);
        check("wrap_state", 128'(state), 128'(3));
        check("wrap_count", 128'(count), 128'(8));
        check("wrap_trig_idx", 128'(trig_idx), 128'(5));
        held = rd_entry;
        check("bp_first", 128'(held), 128'(mk_entry(32'h2C)));
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 128'(rd_valid), 128'(1));
            check("bp_entry", 128'(rd_entry), 128'(held));
            check("bp_count", 128'(count), 128'(8));
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(mk_entry(32'h2C + 32'(4*i)));
        drain("wrap");

        // clamp high: post_cnt = DEPTH-1, trigger at 0x10
        do_arm(1'b1, 32'h10, 3'd7);
        retire_range(32'h0, 11);
        check("c7_pre_state", 128'(state), 128'(2));
        retire(32'h2C);
        check("c7_state", 128'(state), 128'(3));
        check("c7_count", 128'(count), 128'(8));
        check("c7_trig_idx", 128'(trig_idx), 128'(0));
        check("c7_trig_entry", 128'(rd_entry), 128'(mk_entry(32'h10)));

        // clamp low: post_cnt = 0, trigger at 0x10
        do_arm(1'b1, 32'h10, 3'd0);
        retire_range(32'h0, 4);
        check("c0_pre_state", 128'(state), 128'(1));
        retire(32'h10);
        check("c0_state", 128'(state), 128'(3));
        check("c0_count", 128'(count), 128'(5));
        check("c0_trig_idx", 128'(trig_idx), 128'(4));
        check("c0_oldest", 128'(rd_entry), 128'(mk_entry(32'h0)));

        // arm coincident with a pop
        check("ap_pre_valid", 128'(rd_valid), 128'(1));
        rd_ready = 1'b1;
        do_arm(1'b1, 32'h10, 3'd0);
        rd_ready = 1'b0;
        check("ap_state", 128'(state), 128'(1));
        check("ap_count", 128'(count), 128'(0));
        check("ap_valid", 128'(rd_valid), 128'(0));

        // arm coincident with a hit
        retire_range(32'h0, 2);
        check("ah_pre_count", 128'(count), 128'(2));
        set_wb(32'h10);
        do_arm(1'b1, 32'h10, 3'd0);
        wb_valid = 1'b0;
        check("ah_state", 128'(state), 128'(1));
        check("ah_count", 128'(count), 128'(0));
        retire(32'h10);
        check("ah_retrig_state", 128'(state), 128'(3));
        check("ah_retrig_count", 128'(count), 128'(1));
        check("ah_retrig_idx", 128'(trig_idx), 128'(0));
        exp_q.push_back(mk_entry(32'h10));
        drain("ah");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
